variable_prescale_source: RTL and testbench
===========================================

// Module: variable_prescale_source
// PURPOSE
//  Upstream counterpart of the FIR output saturation stage. Accepts signed IN_WIDTH-bit
//  samples on an Avalon-ST sink. Arithmetic-left-shifts each sample by a selectable
//  0..3 bits and saturates the result to OUT_WIDTH. Presents the result on an Avalon-ST
//  source with backpressure, feeding the FIR sink. Counts saturation events for
//  gain-staging diagnostics.
// PARAMETERS
//  IN_WIDTH   12  signed input sample width
//  OUT_WIDTH  14  signed output width (FIR input width); must be >= IN_WIDTH
//  CNT_WIDTH  16  width of saturation event counter
// PORTS
//  clk               in   1          system clock, all logic rising-edge
//  reset_n           in   1          asynchronous, active-low reset
//  sel               in   2          left-shift amount 0..3, sampled per accepted beat
//  ast_sink_data     in   IN_WIDTH   signed input sample
//  ast_sink_error    in   2          upstream error code, forwarded unchanged
//  ast_sink_valid    in   1          input beat valid
//  ast_sink_ready    out  1          block can accept a beat this cycle
//  ast_source_data   out  OUT_WIDTH  shifted, saturated sample
//  ast_source_error  out  2          error code of the beat on ast_source_data
//  ast_source_valid  out  1          output beat valid
//  ast_source_ready  in   1          downstream (FIR) ready
//  sat_clear         in   1          synchronous clear of sat_count
//  sat_count         out  CNT_WIDTH  number of saturated beats, sticky at all-ones
// BEHAVIOUR
//  Reset (async assert, sync release): ast_source_valid=0, ast_source_data=0,
//   ast_source_error=0, sat_count=0, skid empty, ast_sink_ready=1.
//  Sink handshake:
//   - A beat is accepted when ast_sink_valid && ast_sink_ready.
//   - ast_sink_ready is registered and equals !skid_valid.
//   - Ready-latency 0.
//  Datapath, computed at acceptance from that beat's data and sel:
//   - p = sign-extend(data) <<< sel, held in IN_WIDTH+3 bits.
//   - If p > 2^(OUT_WIDTH-1)-1: out = max positive, sat=1.
//   - If p < -2^(OUT_WIDTH-1): out = max negative, sat=1.
//   - Otherwise out = p[OUT_WIDTH-1:0], sat=0.
//  Latency: accepted beat is on ast_source_* the next cycle if the output register is
//   free or drains in the same cycle; otherwise it waits in the 1-entry skid register.
//  Output register / skid (2 entries total, strict FIFO order):
//   - Output register loads when empty or (valid && ast_source_ready).
//   - Source order on load: skid if occupied, else the new beat.
//   - New beat goes to skid only when the output is held (valid && !ready).
//   - While ast_source_valid && !ast_source_ready, data and error hold stable.
//   - No beat is dropped or duplicated.
//  Simultaneous drain and accept with skid empty: new beat replaces the output the
//   same edge; valid stays 1.
//  sel changes mid-stream affect only beats accepted on or after the change.
//  Error pass-through: ast_sink_error travels with its beat. Data is still processed;
//   a nonzero error has no effect on saturation or counting.
//  sat_count:
//   - Increments on each accepted beat with sat=1; holds at 2^CNT_WIDTH-1 (no wrap).
//   - sat_clear with no saturating accept -> 0.
//   - sat_clear together with a saturating accept -> 1.
//  Reset mid-operation: skid and output contents are discarded; no partial beat is
//   emitted after release.
// TESTING (IN_WIDTH=12, OUT_WIDTH=14)
//  1 sel=2, in 0x123, ready=1
//    -> next cycle out=0x048C valid=1, sat_count=0.
//  2 sel=3, in 0x7FF -> out=0x1FFF, sat_count=1;
//    then in 0x800 -> out=0x2000, sat_count=2.
//  3 sel=0, continuous beats 1,2,3,4, ast_source_ready low 3 cycles after beat 1 shown
//    -> ast_sink_ready drops once beat 2 is in skid; output 1,2,3,4 in order, none lost.
//  4 Beat with error=2'b11, sel=1, in 0xFFF
//    -> out=0x3FFE, error=11, sat_count unchanged.
//  5 Preload sat_count=0xFFFE, two saturating beats -> 0xFFFF, stays 0xFFFF;
//    sat_clear alone -> 0; sat_clear with a saturating beat -> 1.
//  6 reset_n low while output held and skid full
//    -> valid=0, sink_ready=1 immediately; after release the first output is the next
//       accepted beat.

Source files
------------

// File: rtl/variable_prescale_source.sv
// variable_prescale_source
// Gain-staging front end for the FIR: takes signed samples on an Avalon-ST sink,
// arithmetic-left-shifts each by 0..3 bits, saturates to OUT_WIDTH and presents the
// result on a backpressured Avalon-ST source through a 2-entry (output + skid) buffer.
// Saturated beats are counted in a sticky counter for diagnostics.
module variable_prescale_source #(
    parameter int IN_WIDTH  = 12,
    parameter int OUT_WIDTH = 14,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           sel,
    input  logic [IN_WIDTH-1:0]  ast_sink_data,
    input  logic [1:0]           ast_sink_error,
    input  logic                 ast_sink_valid,
    output logic                 ast_sink_ready,
    output logic [OUT_WIDTH-1:0] ast_source_data,
    output logic [1:0]           ast_source_error,
    output logic                 ast_source_valid,
    input  logic                 ast_source_ready,
    input  logic                 sat_clear,
    output logic [CNT_WIDTH-1:0] sat_count
);

    // Shifted product width, and a compare width wide enough for both the product
    // and the output limits so the range checks are exact for any legal parameters.
    localparam int PW = IN_WIDTH + 3;
    localparam int CW = ((PW > OUT_WIDTH) ? PW : OUT_WIDTH) + 1;

    localparam logic signed [CW-1:0] MAX_POS =
        {{(CW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [CW-1:0] MIN_NEG =
        {{(CW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    // Registered state
    logic                 out_valid_q,  out_valid_d;
    logic [OUT_WIDTH-1:0] out_data_q,   out_data_d;
    logic [1:0]           out_error_q,  out_error_d;
    logic                 skid_valid_q, skid_valid_d;
    logic [OUT_WIDTH-1:0] skid_data_q,  skid_data_d;
    logic [1:0]           skid_error_q, skid_error_d;
    logic                 sink_ready_q, sink_ready_d;
    logic [CNT_WIDTH-1:0] sat_cnt_q,    sat_cnt_d;

    // Combinational datapath signals
    logic signed [PW-1:0] ext_s;
    logic signed [PW-1:0] shifted_s;
    logic signed [CW-1:0] wide_s;
    logic [OUT_WIDTH-1:0] new_data_s;
    logic                 new_sat_s;
    logic                 accept_s;
    logic                 out_load_s;

    assign accept_s   = ast_sink_valid && sink_ready_q;
    assign out_load_s = !out_valid_q || ast_source_ready;

    // Shift the incoming sample by sel and clamp it into the signed output range.
    always_comb begin
        ext_s      = {{3{ast_sink_data[IN_WIDTH-1]}}, ast_sink_data};
        shifted_s  = ext_s <<< sel;
        wide_s     = {{(CW-PW){shifted_s[PW-1]}}, shifted_s};
        new_data_s = wide_s[OUT_WIDTH-1:0];
        new_sat_s  = 1'b0;
        if (wide_s > MAX_POS) begin
            new_data_s = MAX_POS[OUT_WIDTH-1:0];
            new_sat_s  = 1'b1;
        end else if (wide_s < MIN_NEG) begin
            new_data_s = MIN_NEG[OUT_WIDTH-1:0];
            new_sat_s  = 1'b1;
        end else begin
            new_data_s = wide_s[OUT_WIDTH-1:0];
            new_sat_s  = 1'b0;
        end
    end

    // Output/skid steering: the output reloads from the skid first (FIFO order), else
    // from the new beat; a new beat parks in the skid only while the output is held.
    // The sink is only ready while the skid is empty, so skid-full and accept never
    // coincide.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_error_d  = out_error_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_error_d = skid_error_q;
        if (out_load_s) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_error_d  = skid_error_q;
                skid_valid_d = 1'b0;
            end else if (accept_s) begin
                out_valid_d  = 1'b1;
                out_data_d   = new_data_s;
                out_error_d  = ast_sink_error;
            end else begin
                out_valid_d  = 1'b0;
            end
        end else begin
            if (accept_s) begin
                skid_valid_d = 1'b1;
                skid_data_d  = new_data_s;
                skid_error_d = ast_sink_error;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
        sink_ready_d = !skid_valid_d;
    end

    // Saturation counter: clear wins but still counts a same-cycle saturating beat;
    // otherwise increments and sticks at all-ones.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_clear) begin
            sat_cnt_d = (accept_s && new_sat_s) ? {{(CNT_WIDTH-1){1'b0}}, 1'b1}
                                                : {CNT_WIDTH{1'b0}};
        end else if (accept_s && new_sat_s && (sat_cnt_q != CNT_MAX)) begin
            sat_cnt_d = sat_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            sat_cnt_d = sat_cnt_q;
        end
    end

    // State registers; reset discards any buffered beats and reopens the sink.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= {OUT_WIDTH{1'b0}};
            out_error_q  <= 2'b00;
            skid_valid_q <= 1'b0;
            skid_data_q  <= {OUT_WIDTH{1'b0}};
            skid_error_q <= 2'b00;
            sink_ready_q <= 1'b1;
            sat_cnt_q    <= {CNT_WIDTH{1'b0}};
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_error_q  <= out_error_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_error_q <= skid_error_d;
            sink_ready_q <= sink_ready_d;
            sat_cnt_q    <= sat_cnt_d;
        end
    end

    assign ast_sink_ready   = sink_ready_q;
    assign ast_source_valid = out_valid_q;
    assign ast_source_data  = out_data_q;
    assign ast_source_error = out_error_q;
    assign sat_count        = sat_cnt_q;

endmodule

// File: tb/tb_variable_prescale_source.sv
// Self-checking bench for variable_prescale_source (IN_WIDTH=12, OUT_WIDTH=14).
// Reference model: in-flight beats as a queue of at most two entries, values from
// plain integer multiply-and-clamp, counter as a saturating integer.
module tb_variable_prescale_source;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [11:0] ast_sink_data = 12'd0;
    logic [1:0]  ast_sink_error = 2'd0;
    logic        ast_sink_valid = 1'b0;
    logic        ast_sink_ready;
    logic [13:0] ast_source_data;
    logic [1:0]  ast_source_error;
    logic        ast_source_valid;
    logic        ast_source_ready = 1'b1;
    logic        sat_clear = 1'b0;
    logic [15:0] sat_count;

    variable_prescale_source #(.IN_WIDTH(12), .OUT_WIDTH(14), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .sel(sel),
        .ast_sink_data(ast_sink_data), .ast_sink_error(ast_sink_error),
        .ast_sink_valid(ast_sink_valid), .ast_sink_ready(ast_sink_ready),
        .ast_source_data(ast_source_data), .ast_source_error(ast_source_error),
        .ast_source_valid(ast_source_valid), .ast_source_ready(ast_source_ready),
        .sat_clear(sat_clear), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] d;
        logic [1:0]  e;
    } beat_t;

    typedef struct {
        logic [1:0]  sel;
        logic [11:0] din;
        logic [1:0]  err;
        logic [13:0] exp_d;
        logic        exp_sat;
    } vec_t;

    beat_t q[$];
    int    mcnt = 0;
    int    total = 0;
    int    bad = 0;
    bit    last_acc;
    bit    obs_en = 1'b0;
    int    obs[$];
    bit    saw_not_ready;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Shift by multiplication and clamp into [-8192, 8191].
    function automatic beat_t ref_beat(input logic [1:0] s, input logic [11:0] d,
                                       input logic [1:0] e, output bit sat);
        beat_t b;
        int v;
        v = int'($signed(d)) * (1 << s);
        sat = 1'b0;
        if (v > 8191) begin v = 8191; sat = 1'b1; end
        if (v < -8192) begin v = -8192; sat = 1'b1; end
        b.d = v[13:0];
        b.e = e;
        return b;
    endfunction

    // One clock: compare at negedge against the model, advance the model, return #1
    // after the following posedge so the caller can drive the next inputs.
    task automatic cycle();
        bit acc, drn, sat;
        beat_t nb;
        @(negedge clk);
        check("valid", int'(ast_source_valid), int'(q.size() > 0));
        check("sink_ready", int'(ast_sink_ready), int'(q.size() < 2));
        check("sat_count", int'(sat_count), mcnt);
        if (q.size() > 0) begin
            check("data", int'(ast_source_data), int'(q[0].d));
            check("error", int'(ast_source_error), int'(q[0].e));
        end
        if (!ast_sink_ready) saw_not_ready = 1'b1;
        acc = ast_sink_valid && (q.size() < 2);
        drn = (q.size() > 0) && ast_source_ready;
        nb = ref_beat(sel, ast_sink_data, ast_sink_error, sat);
        if (drn) begin
            if (obs_en) obs.push_back(int'(ast_source_data));
            void'(q.pop_front());
        end
        if (acc) q.push_back(nb);
        if (sat_clear) mcnt = (acc && sat) ? 1 : 0;
        else if (acc && sat && mcnt < 65535) mcnt++;
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[11];
    int   prev;
    int   idx;
    bit   dummy;

    initial begin
        vecs[0]  = '{2'd2, 12'h123, 2'd0, 14'h048C, 1'b0};
        vecs[1]  = '{2'd3, 12'h7FF, 2'd0, 14'h1FFF, 1'b1};
        vecs[2]  = '{2'd3, 12'h800, 2'd0, 14'h2000, 1'b1};
        vecs[3]  = '{2'd1, 12'hFFF, 2'd3, 14'h3FFE, 1'b0};
        vecs[4]  = '{2'd0, 12'h7FF, 2'd0, 14'h07FF, 1'b0};
        vecs[5]  = '{2'd3, 12'h400, 2'd0, 14'h1FFF, 1'b1};
        vecs[6]  = '{2'd3, 12'h3FF, 2'd1, 14'h1FF8, 1'b0};
        vecs[7]  = '{2'd3, 12'hC00, 2'd0, 14'h2000, 1'b0};
        vecs[8]  = '{2'd3, 12'hBFF, 2'd2, 14'h2000, 1'b1};
        vecs[9]  = '{2'd2, 12'h800, 2'd0, 14'h2000, 1'b0};
        vecs[10] = '{2'd1, 12'h123, 2'd1, 14'h0246, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", int'(ast_source_valid), 0);
        check("rst_data", int'(ast_source_data), 0);
        check("rst_error", int'(ast_source_error), 0);
        check("rst_ready", int'(ast_sink_ready), 1);
        check("rst_count", int'(sat_count), 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vector table: one beat each, checked on the following cycle.
        foreach (vecs[i]) begin
            sel = vecs[i].sel; ast_sink_data = vecs[i].din; ast_sink_error = vecs[i].err;
            ast_sink_valid = 1'b1; ast_source_ready = 1'b1;
            prev = mcnt;
            cycle();
            ast_sink_valid = 1'b0;
            check("vec_valid", int'(ast_source_valid), 1);
            check("vec_data", int'(ast_source_data), int'(vecs[i].exp_d));
            check("vec_error", int'(ast_source_error), int'(vecs[i].err));
            check("vec_count", int'(sat_count), prev + int'(vecs[i].exp_sat));
            cycle();
        end

        // Backpressure: beats 1..4, downstream stalls three cycles after beat 1 shows.
        sel = 2'd0; ast_sink_error = 2'd0;
        idx = 0; saw_not_ready = 1'b0; obs_en = 1'b1; obs.delete();
        for (int t = 0; t < 14; t++) begin
            ast_sink_valid = (idx < 4);
            ast_sink_data = 12'(idx + 1);
            ast_source_ready = !(t >= 1 && t <= 3);
            cycle();
            if (last_acc) idx++;
        end
        ast_sink_valid = 1'b0;
        obs_en = 1'b0;
        check("bp_sink_ready_dropped", int'(saw_not_ready), 1);
        check("bp_count", obs.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check("bp_order", (k < obs.size()) ? obs[k] : -1, k + 1);
        end

        // Sticky counter: clear, fill to 0xFFFE, hold at 0xFFFF, clear rules.
        ast_source_ready = 1'b1;
        sat_clear = 1'b1; cycle(); sat_clear = 1'b0;
        check("clr_alone", int'(sat_count), 0);
        sel = 2'd3; ast_sink_data = 12'h7FF; ast_sink_valid = 1'b1;
        for (int k = 0; k < 65534; k++) cycle();
        check("cnt_fffe", int'(sat_count), 16'hFFFE);
        cycle();
        check("cnt_ffff", int'(sat_count), 16'hFFFF);
        cycle();
        check("cnt_sticky", int'(sat_count), 16'hFFFF);
        ast_sink_valid = 1'b0; sat_clear = 1'b1;
        cycle();
        check("clr_to_zero", int'(sat_count), 0);
        ast_sink_valid = 1'b1;
        cycle();
        check("clr_with_sat", int'(sat_count), 1);
        sat_clear = 1'b0; ast_sink_valid = 1'b0;
        cycle(); cycle();

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            ast_sink_valid = ($urandom_range(0, 3) != 0);
            ast_source_ready = ($urandom_range(0, 2) != 0);
            sel = 2'($urandom_range(0, 3));
            ast_sink_data = 12'($urandom);
            ast_sink_error = 2'($urandom);
            sat_clear = ($urandom_range(0, 63) == 0);
            cycle();
        end
        sat_clear = 1'b0;

        // Reset with output held and skid full.
        ast_source_ready = 1'b0; ast_sink_data = 12'h0AA; sel = 2'd0;
        for (int k = 0; k < 20 && q.size() < 2; k++) begin
            ast_sink_valid = 1'b1;
            cycle();
        end
        ast_sink_valid = 1'b0;
        check("pre_rst_full", q.size(), 2);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(ast_source_valid), 0);
        check("mid_rst_ready", int'(ast_sink_ready), 1);
        check("mid_rst_count", int'(sat_count), 0);
        q.delete(); mcnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        ast_source_ready = 1'b1;
        @(posedge clk);
        #1;
        cycle();
        ast_sink_data = 12'h055; ast_sink_valid = 1'b1;
        cycle();
        ast_sink_valid = 1'b0;
        check("post_rst_first", int'(ast_source_data), 16'h0055);
        check("post_rst_valid", int'(ast_source_valid), 1);
        cycle(); cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
